// File: rtl/tc_pkg.sv
// Shared types and constants for the tc traffic checker.
package tc_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [2:0] E_NONE         = 3'd0;
   localparam logic [2:0] E_EARLY_LAST   = 3'd1;
   localparam logic [2:0] E_MISSING_LAST = 3'd2;
   localparam logic [2:0] E_BAD_KEEP     = 3'd3;
   localparam logic [2:0] E_BAD_DATA     = 3'd4;
   localparam logic [2:0] E_EXTRA_BEAT   = 3'd5;

   localparam int CNT_W = 16;
   localparam int LFB_W = 8;
   localparam int THR_W = 16;

endpackage

// File: rtl/tc_throttle.sv
// TREADY duty generator: M cycles high, N cycles low, restarted whenever en drops.
module tc_throttle
   import tc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [THR_W-1:0] M,
   input  logic [THR_W-1:0] N,
   output logic             rdy
);

   logic [THR_W:0] r_cnt;
   logic           r_rdy;
   logic [THR_W:0] w_period;
   logic [THR_W:0] w_cnt_inc;

   assign w_period  = {1'b0, M} + {1'b0, N};
   assign w_cnt_inc = r_cnt + (THR_W+1)'(1);

   // The first enabled cycle is always high, so stale M/N on the entry edge cannot matter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_rdy <= 1'b0;
      end else if (!en) begin
         r_cnt <= '0;
         r_rdy <= 1'b0;
      end else begin
         r_rdy <= (r_cnt == '0) || (M == '0) || (N == '0) || (r_cnt < {1'b0, M});
         if ((r_cnt == '0) || (w_cnt_inc < w_period))
            r_cnt <= w_cnt_inc;
         else
            r_cnt <= '0;
      end
   end

   assign rdy = r_rdy;

endmodule

// File: rtl/tc.sv
// AXI-Stream traffic checker: throttles TREADY and checks length, TKEEP, TLAST and payload.
module tc
   import tc_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        mode,
   input  logic [31:0]        num_packets,
   input  logic [31:0]        num_flits,
   input  logic [31:0]        last_flit_bytes,
   input  logic [31:0]        M,
   input  logic [31:0]        N,
   input  logic [WIDTH-1:0]   TDATA,
   input  logic [WIDTH/8-1:0] TKEEP,
   input  logic               TVALID,
   output logic               TREADY,
   input  logic               TLAST,
   output logic               done,
   output logic               err,
   output logic [2:0]         err_code,
   output logic [15:0]        pkt_cnt,
   output logic [31:0]        beat_cnt
);

   localparam int KW = WIDTH / 8;

   state_t             r_state;
   logic [CNT_W-1:0]   r_num_pkts;
   logic [CNT_W-1:0]   r_num_flits;
   logic [LFB_W-1:0]   r_lfb;
   logic [THR_W-1:0]   r_m;
   logic [THR_W-1:0]   r_n;
   logic               r_chk;
   logic [CNT_W-1:0]   r_fi;
   logic [CNT_W-1:0]   r_pkt_cnt;
   logic [31:0]        r_beat_cnt;
   logic               r_done;
   logic               r_err;
   logic [2:0]         r_err_code;
   logic               r_drain;

   logic               w_thr_en;
   logic               w_thr_rdy;
   logic               w_acc;
   logic               w_last_pos;
   logic [LFB_W-1:0]   w_lfb;
   logic [KW-1:0]      w_last_keep;
   logic [WIDTH-1:0]   w_exp_data;
   logic [2:0]         w_code;
   logic               w_unused;

   assign w_unused = &{1'b0, mode[31:1], num_packets[31:16], num_flits[31:16],
                       last_flit_bytes[31:8], M[31:16], N[31:16]};

   assign w_thr_en = mode[0] && ((r_state == S_IDLE) || (r_state == S_RUN));

   tc_throttle u_throttle (
      .clk (clk),
      .rst (rst),
      .en  (w_thr_en),
      .M   (r_m),
      .N   (r_n),
      .rdy (w_thr_rdy)
   );

   // Both terms are flops, so TREADY never sees TVALID combinationally.
   assign TREADY = r_drain | w_thr_rdy;
   assign w_acc  = TVALID && TREADY;

   assign w_lfb = ((last_flit_bytes[7:0] == '0) || (last_flit_bytes[7:0] > LFB_W'(KW)))
                  ? LFB_W'(KW) : last_flit_bytes[7:0];

   assign w_last_pos = ({1'b0, r_fi} + (CNT_W+1)'(1)) == {1'b0, r_num_flits};
   assign w_exp_data = WIDTH'(r_beat_cnt);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_last_keep = '0;
      for (int i = 0; i < KW; i++)
         w_last_keep[i] = (i < int'(r_lfb));
   end

   always_comb begin
      w_code = E_NONE;
      if (TLAST && !w_last_pos)
         w_code = E_EARLY_LAST;
      else if (!TLAST && w_last_pos)
         w_code = E_MISSING_LAST;
      else if (w_last_pos ? (TKEEP != w_last_keep) : (TKEEP != '1))
         w_code = E_BAD_KEEP;
      else if (r_chk && (TDATA != w_exp_data))
         w_code = E_BAD_DATA;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_num_pkts  <= '0;
         r_num_flits <= '0;
         r_lfb       <= '0;
         r_m         <= '0;
         r_n         <= '0;
         r_chk       <= 1'b0;
         r_fi        <= '0;
         r_pkt_cnt   <= '0;
         r_beat_cnt  <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= E_NONE;
         r_drain     <= 1'b0;
      end else if (!mode[0]) begin
         r_state    <= S_IDLE;
         r_fi       <= '0;
         r_pkt_cnt  <= '0;
         r_beat_cnt <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= E_NONE;
         r_drain    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_num_pkts  <= num_packets[15:0];
               r_num_flits <= (num_flits[15:0] == '0) ? CNT_W'(1) : num_flits[15:0];
               r_lfb       <= w_lfb;
               r_m         <= M[15:0];
               r_n         <= N[15:0];
               r_chk       <= mode[1];
               r_state     <= S_RUN;
            end
            S_RUN: begin
               if (r_num_pkts == '0) begin
                  r_drain <= 1'b1;
                  if (w_acc) begin
                     r_err      <= 1'b1;
                     r_err_code <= E_EXTRA_BEAT;
                     r_state    <= S_ERR;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end else if (w_acc) begin
                  if (w_code != E_NONE) begin
                     r_err      <= 1'b1;
                     r_err_code <= w_code;
                     r_drain    <= 1'b1;
                     r_state    <= S_ERR;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 32'd1;
                     if (w_last_pos) begin
                        r_fi      <= '0;
                        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                        if ((r_pkt_cnt + CNT_W'(1)) == r_num_pkts) begin
                           r_done  <= 1'b1;
                           r_drain <= 1'b1;
                           r_state <= S_DONE;
                        end
                     end else begin
                        r_fi <= r_fi + CNT_W'(1);
                     end
                  end
               end
            end
            S_DONE: begin
               if (w_acc) begin
                  r_done     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= E_EXTRA_BEAT;
                  r_state    <= S_ERR;
               end
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign done     = r_done;
   assign err      = r_err;
   assign err_code = r_err_code;
   assign pkt_cnt  = r_pkt_cnt;
   assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_tc.sv
// Directed self-checking bench for the tc traffic checker.
module tb_tc;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mode, num_packets, num_flits, last_flit_bytes, M, N;
   logic [63:0] TDATA;
   logic [7:0]  TKEEP;
   logic        TVALID, TLAST;
   logic        TREADY, done, err;
   logic [2:0]  err_code;
   logic [15:0] pkt_cnt;
   logic [31:0] beat_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   tc #(.WIDTH(64)) dut (
      .clk             (clk),
      .rst             (rst),
      .mode            (mode),
      .num_packets     (num_packets),
      .num_flits       (num_flits),
      .last_flit_bytes (last_flit_bytes),
      .M               (M),
      .N               (N),
      .TDATA           (TDATA),
      .TKEEP           (TKEEP),
      .TVALID          (TVALID),
      .TREADY          (TREADY),
      .TLAST           (TLAST),
      .done            (done),
      .err             (err),
      .err_code        (err_code),
      .pkt_cnt         (pkt_cnt),
      .beat_cnt        (beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Program the configuration and let the IDLE->RUN edge pass.
   task automatic start_run(input logic [31:0] np, input logic [31:0] nf, input logic [31:0] lfb,
                            input logic [31:0] m, input logic [31:0] n, input logic [31:0] md);
      num_packets = np; num_flits = nf; last_flit_bytes = lfb; M = m; N = n; mode = md;
      @(posedge clk); #1;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      bit got = 1'b0;
      int n   = 0;
      TDATA = d; TKEEP = k; TLAST = l; TVALID = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk);
         got = TREADY;
         @(posedge clk); #1;
         n++;
      end
      TVALID = 1'b0; TLAST = 1'b0;
      if (!got) check("beat_timeout", 0, 1);
   endtask

   task automatic go_idle(input string tag);
      mode = 32'd0;
      @(posedge clk); #1;
      check({tag, "_tready"}, TREADY, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_code"}, err_code, 0);
      check({tag, "_pkt"}, pkt_cnt, 0);
      check({tag, "_beat"}, beat_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats, c;
      logic rdy;
      logic [63:0] d;

      rst = 1'b0; mode = '0; num_packets = '0; num_flits = '0; last_flit_bytes = '0;
      M = '0; N = '0; TDATA = '0; TKEEP = '0; TVALID = 1'b0; TLAST = 1'b0;
      #12;
      check("rst_tready", TREADY, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_code", err_code, 0);
      check("rst_pkt", pkt_cnt, 0);
      check("rst_beat", beat_cnt, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("idle_tready", TREADY, 0);

      // 3 packets x 4 beats, full keep, counting payload
      start_run(3, 4, 8, 0, 0, 3);
      check("run_tready", TREADY, 1);
      for (int i = 0; i < 12; i++) begin
         d = 64'(i);
         send_beat(d, 8'hFF, (i % 4) == 3);
         if (i == 10) check("mid_done", done, 0);
      end
      check("t1_done", done, 1);
      check("t1_pkt", pkt_cnt, 3);
      check("t1_beat", beat_cnt, 12);
      check("t1_err", err, 0);
      check("t1_tready", TREADY, 1);
      go_idle("t1_idle");

      // throttle M=2 N=3 with TVALID held
      TDATA = 64'd0; TKEEP = 8'hFF; TLAST = 1'b0; TVALID = 1'b1;
      start_run(2, 5, 8, 2, 3, 3);
      beats = 0; c = 0;
      while (beats < 10 && c < 40) begin
         @(negedge clk);
         rdy = TREADY;
         check("thr_pattern", rdy, ((c % 5) < 2) ? 1 : 0);
         @(posedge clk); #1;
         if (rdy) begin
            beats++;
            TDATA = 64'(beats);
            TLAST = (beats % 5) == 4;
         end
         c++;
      end
      TVALID = 1'b0; TLAST = 1'b0;
      check("thr_beats", beats, 10);
      check("thr_done", done, 1);
      check("thr_pkt", pkt_cnt, 2);
      check("thr_err", err, 0);
      go_idle("t2_idle");

      // early TLAST on second beat of a 4-beat packet
      start_run(2, 4, 8, 0, 0, 3);
      send_beat(64'd0, 8'hFF, 1'b0);
      send_beat(64'd1, 8'hFF, 1'b1);
      check("early_err", err, 1);
      check("early_code", err_code, 1);
      check("early_pkt", pkt_cnt, 0);
      check("early_tready", TREADY, 1);
      check("early_done", done, 0);
      go_idle("t3_idle");

      // lfb=3: full keep on last beat is wrong, 0x07 is right
      start_run(1, 2, 3, 0, 0, 3);
      send_beat(64'd0, 8'hFF, 1'b0);
      send_beat(64'd1, 8'hFF, 1'b1);
      check("keep_err", err, 1);
      check("keep_code", err_code, 3);
      go_idle("t4a_idle");
      start_run(1, 2, 3, 0, 0, 3);
      send_beat(64'd0, 8'hFF, 1'b0);
      send_beat(64'd1, 8'h07, 1'b1);
      check("keep_ok_done", done, 1);
      check("keep_ok_err", err, 0);
      go_idle("t4b_idle");

      // payload 6 instead of 5 on beat 5, checked then unchecked
      start_run(1, 8, 8, 0, 0, 3);
      for (int i = 0; i < 8; i++) begin
         d = (i == 5) ? 64'd6 : 64'(i);
         send_beat(d, 8'hFF, i == 7);
      end
      check("data_err", err, 1);
      check("data_code", err_code, 4);
      check("data_done", done, 0);
      go_idle("t5a_idle");
      start_run(1, 8, 8, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         d = (i == 5) ? 64'd6 : 64'(i);
         send_beat(d, 8'hFF, i == 7);
      end
      check("nochk_done", done, 1);
      check("nochk_err", err, 0);
      check("nochk_beat", beat_cnt, 8);

      // extra beat after done
      send_beat(64'd8, 8'hFF, 1'b1);
      check("extra_err", err, 1);
      check("extra_code", err_code, 5);
      check("extra_done", done, 0);
      go_idle("t6_idle");

      // reset in the middle of a packet
      start_run(1, 4, 8, 0, 0, 3);
      send_beat(64'd0, 8'hFF, 1'b0);
      send_beat(64'd1, 8'hFF, 1'b0);
      check("pre_rst_beat", beat_cnt, 2);
      #2 rst = 1'b0;
      #1;
      check("mrst_tready", TREADY, 0);
      check("mrst_beat", beat_cnt, 0);
      check("mrst_pkt", pkt_cnt, 0);
      check("mrst_err", err, 0);
      mode = 32'd0;
      #2 rst = 1'b1;
      @(posedge clk); #1;

      // zero packets: DONE one cycle after entering RUN
      start_run(0, 1, 8, 0, 0, 1);
      check("zero_run_done", done, 0);
      @(posedge clk); #1;
      check("zero_done", done, 1);
      check("zero_err", err, 0);
      check("zero_beat", beat_cnt, 0);
      go_idle("t7_idle");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tc.md
# tc

Traffic checker: the AXI-Stream sink facing the `tg` traffic generator. Consumes the packet stream `tg` emits, throttles it with a programmable TREADY duty pattern, and checks packet length, TKEEP, TLAST placement and payload sequence against the same configuration words used to program `tg`. Sits at the far end of the link under test, in benches and on-chip loopback builds, and reports completion, packet/beat counts and the first error seen.

## Interface
- `WIDTH`, 64, TDATA width in bits; multiple of 8, 8..512
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-low reset
- `mode`  in  32  bit 0 = enable run, bit 1 = check payload; bits 31:2 ignored
- `num_packets`  in  32  bits 15:0 used: packets expected per run
- `num_flits`  in  32  bits 15:0 used: beats per packet; 0 treated as 1
- `last_flit_bytes`  in  32  bits 7:0 used: valid bytes in last beat; 0 or > WIDTH/8 treated as WIDTH/8
- `M`  in  32  bits 15:0 used: TREADY-high cycles per throttle period
- `N`  in  32  bits 15:0 used: TREADY-low cycles per throttle period
- `TDATA`  in  WIDTH  stream payload
- `TKEEP`  in  WIDTH/8  byte enables
- `TVALID`  in  1  upstream valid
- `TREADY`  out  1  registered ready
- `TLAST`  in  1  end of packet
- `done`  out  1  all expected packets received cleanly
- `err`  out  1  sticky error flag
- `err_code`  out  3  code of first error
- `pkt_cnt`  out  16  packets completed
- `beat_cnt`  out  32  beats accepted this run

## Operation
- States: IDLE, RUN, DONE, ERR.
- IDLE: TREADY=0, counters cleared. `mode[0]`=1 -> RUN; config inputs sampled into registers on that transition and ignored afterwards.
- RUN: beat accepted when TVALID&TREADY. Per beat: flit index `fi` (per packet) and `beat_cnt` increment.
- Expected payload: `beat_cnt` value zero-extended to WIDTH (0 for first beat of run). Checked only if sampled `mode[1]`=1.
- Checks per accepted beat, priority order: TLAST with fi+1 < num_flits -> EARLY_LAST(1); no TLAST at fi+1 == num_flits -> MISSING_LAST(2); non-last beat TKEEP != all-ones, or last beat TKEEP != (1<<lfb)-1 -> BAD_KEEP(3); payload mismatch -> BAD_DATA(4).
- Any failure -> ERR; `err`=1, `err_code` holds first code, sticky until IDLE.
- Last beat of packet: `fi`=0, `pkt_cnt`++. When `pkt_cnt` reaches num_packets -> DONE.
- num_packets=0: RUN -> DONE one cycle later with no beat accepted.
- DONE: `done`=1, TREADY=1; any accepted beat -> ERR with EXTRA_BEAT(5), `done` drops.
- ERR: TREADY=1 (drain), counts frozen.
- `mode[0]`=0 in any state -> IDLE next cycle; all outputs to reset values.
- Throttle: TREADY high M cycles then low N cycles, repeating from RUN entry. M=0 or N=0 -> TREADY constantly 1 in RUN. Throttle counts cycles, not beats.

## Timing
- Reset values: TREADY=0, done=0, err=0, err_code=0, pkt_cnt=0, beat_cnt=0, state IDLE.
- TREADY first high the cycle after IDLE -> RUN edge.
- Beat accepted at edge k: counters, `err`, `err_code`, `done` update at edge k (visible cycle k+1).
- TVALID/TDATA may change while TREADY=0; only handshaken beats are checked.
- TREADY never combinationally depends on TVALID.
- Reset asserted mid-packet: immediate return to reset values; partial packet discarded.
- `pkt_cnt` wraps at 16 bits only if num_packets=0xFFFF ... never reached (DONE first); `beat_cnt` wraps modulo 2^32, payload compare uses same wrap.

## Structure
- Package `tc_pkg`: state enum (IDLE, RUN, DONE, ERR), error code constants 0..5, config field widths.
- Sub-module `tc_throttle`: M/N counter producing the ready pattern; inputs clk, rst, en, M, N; output rdy.
- Top holds FSM, flit/packet/beat counters, keep-mask generator, comparator.

## Test plan
- num_packets=3, num_flits=4, lfb=8, M=0, counting payload -> 12 beats, pkt_cnt=3, done=1 one cycle after 12th beat, err=0.
- M=2, N=3, TVALID held 1 -> TREADY pattern 1,1,0,0,0 repeating; 2 packets of 5 beats complete, done=1.
- TLAST on beat 2 of num_flits=4 -> err=1, err_code=1, pkt_cnt=0, state ERR, TREADY=1.
- lfb=3, last beat TKEEP=0xFF -> err_code=3; repeat with TKEEP=0x07 -> done=1.
- Beat 5 payload 0x6 instead of 0x5, mode[1]=1 -> err_code=4; same with mode[1]=0 -> done=1.
- Extra beat after done -> err_code=5, done=0; drop mode[0] -> all outputs 0 next cycle; rst low mid-packet -> reset values immediately.
